// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with trap entry, mret, interrupt arbitration and 64-bit counters.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   we_i/waddr_i/wdata_i      CSR write port (takes effect at the next rising edge)
//   raddr_i/rdata_o           combinational CSR read port
//   illegal_o                 current read/write access is illegal
//   trap_i/trap_cause_i/trap_pc_i/trap_val_i   synchronous exception entry
//   mret_i                    return from trap
//   retire_i                  one instruction retired (minstret increment)
//   irq_ext_i/irq_tmr_i/irq_sw_i   MEI/MTI/MSI lines, sampled into mip
//   irq_req_o/irq_cause_o     an enabled interrupt is pending, and its code
//   irq_take_i                core takes irq_cause_o this cycle
//   trap_target_o             handler address
//   mepc_o, priv_o            current mepc and privilege (11 = M, 00 = U)
module csr_trap_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter int              HART_ID   = 0,
    parameter bit              VEC_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [11:0]     waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [11:0]     raddr_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    input  logic            trap_i,
    input  logic [4:0]      trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic            irq_ext_i,
    input  logic            irq_tmr_i,
    input  logic            irq_sw_i,
    output logic            irq_req_o,
    output logic [4:0]      irq_cause_o,
    input  logic            irq_take_i,
    output logic [XLEN-1:0] trap_target_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [1:0]      priv_o
);
    localparam logic [1:0]      PRIV_M    = 2'b11;
    localparam logic [1:0]      PRIV_U    = 2'b00;
    localparam logic [XLEN-1:0] ALIGN     = ~XLEN'(3);
    localparam logic [XLEN-1:0] MIE_MASK  = XLEN'(12'h888);
    localparam logic [XLEN-1:0] MISA      = {((XLEN == 64) ? 2'd2 : 2'd1), {(XLEN-2){1'b0}}} | XLEN'(32'h0010_0100);
    localparam logic [XLEN-1:0] MTVEC_INI = VEC_EN ? MTVEC_RST : (MTVEC_RST & ALIGN);

    function automatic logic implemented(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, [12'h340:12'h344],
                         12'hB00, 12'hB02, 12'hB80, 12'hB82, [12'hF11:12'hF14]};
    endfunction

    function automatic logic read_only(input logic [11:0] a);
        return a inside {12'h301, [12'hF11:12'hF14]};
    endfunction

    logic [1:0]        priv;
    logic              status_mie, status_mpie;
    logic [1:0]        status_mpp;
    logic [XLEN-1:0]   mie, mtvec, mscratch, mepc, mcause, mtval;
    logic [2:0]        irq_q;
    logic [2*XLEN-1:0] mcycle, minstret, cyc_inc, ins_inc;
    logic [XLEN-1:0]   mstatus, mip, pend, base;
    logic              wr;

    assign mstatus = XLEN'({status_mpp, 3'b0, status_mpie, 3'b0, status_mie, 3'b0});
    assign mip     = XLEN'({irq_q[2], 3'b0, irq_q[1], 3'b0, irq_q[0], 3'b0});
    assign pend    = mip & mie;
    assign irq_req_o   = ((priv == PRIV_M && status_mie) || priv == PRIV_U) && |pend;
    assign irq_cause_o = pend[11] ? 5'd11 : pend[3] ? 5'd3 : pend[7] ? 5'd7 : 5'd0;
    // Vectoring only applies to an interrupt about to be taken; a concurrent exception uses the base.
    assign base          = mtvec & ALIGN;
    assign trap_target_o = (mtvec[1:0] == 2'b01 && irq_req_o && !trap_i) ? base + XLEN'({irq_cause_o, 2'b00}) : base;
    assign mepc_o = mepc;
    assign priv_o = priv;
    assign illegal_o = !implemented(raddr_i) || priv == PRIV_U ||
                       (we_i && (!implemented(waddr_i) || read_only(waddr_i)));
    // Trap, interrupt entry and mret all discard a same-cycle CSR write.
    assign wr = we_i && priv == PRIV_M && implemented(waddr_i) && !read_only(waddr_i) &&
                !trap_i && !irq_take_i && !mret_i;
    assign cyc_inc = mcycle + (2*XLEN)'(1);
    assign ins_inc = minstret + (2*XLEN)'(retire_i);

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            12'h300: rdata_o = mstatus;
            12'h301: rdata_o = MISA;
            12'h304: rdata_o = mie;
            12'h305: rdata_o = mtvec;
            12'h340: rdata_o = mscratch;
            12'h341: rdata_o = mepc;
            12'h342: rdata_o = mcause;
            12'h343: rdata_o = mtval;
            12'h344: rdata_o = mip;
            12'hB00: rdata_o = mcycle[XLEN-1:0];
            12'hB02: rdata_o = minstret[XLEN-1:0];
            12'hB80: rdata_o = mcycle[2*XLEN-1:XLEN];
            12'hB82: rdata_o = minstret[2*XLEN-1:XLEN];
            12'hF14: rdata_o = XLEN'(HART_ID);
            default: rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            priv        <= PRIV_M;
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            status_mpp  <= PRIV_M;
            mie         <= '0;
            mtvec       <= MTVEC_INI;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
            irq_q       <= '0;
            mcycle      <= '0;
            minstret    <= '0;
        end else begin
            irq_q <= {irq_ext_i, irq_tmr_i, irq_sw_i};
            // A write to one counter half replaces only that half's increment.
            mcycle   <= {(wr && waddr_i == 12'hB80) ? wdata_i : cyc_inc[2*XLEN-1:XLEN],
                         (wr && waddr_i == 12'hB00) ? wdata_i : cyc_inc[XLEN-1:0]};
            minstret <= {(wr && waddr_i == 12'hB82) ? wdata_i : ins_inc[2*XLEN-1:XLEN],
                         (wr && waddr_i == 12'hB02) ? wdata_i : ins_inc[XLEN-1:0]};
            if (trap_i || irq_take_i) begin
                mepc        <= trap_pc_i & ALIGN;
                mcause      <= trap_i ? XLEN'(trap_cause_i) : {1'b1, {(XLEN-6){1'b0}}, irq_cause_o};
                mtval       <= trap_i ? trap_val_i : '0;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
                status_mpp  <= priv;
                priv        <= PRIV_M;
            end else if (mret_i) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
                priv        <= status_mpp;
                status_mpp  <= PRIV_U;
            end else if (wr) begin
                case (waddr_i)
                    12'h300: begin
                        status_mie  <= wdata_i[3];
                        status_mpie <= wdata_i[7];
                        status_mpp  <= (wdata_i[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
                    end
                    12'h304: mie      <= wdata_i & MIE_MASK;
                    12'h305: mtvec    <= {wdata_i[XLEN-1:2], !VEC_EN ? 2'b00 : wdata_i[1] ? mtvec[1:0] : wdata_i[1:0]};
                    12'h340: mscratch <= wdata_i;
                    12'h341: mepc     <= wdata_i & ALIGN;
                    12'h342: mcause   <= wdata_i;
                    12'h343: mtval    <= wdata_i;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: randomized and directed checks of csr_trap_unit against a behavioural CSR model.
module tb_csr_trap_unit;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0;
    logic [11:0] wa = '0, ra = 12'h300;
    logic [31:0] wd = '0, tpc = '0, tval = '0;
    logic [4:0]  tcause = '0;
    logic        trap = 1'b0, mret = 1'b0, retire = 1'b0, take = 1'b0;
    logic        ext = 1'b0, tmr = 1'b0, sw = 1'b0;
    logic [31:0] rdata, target, mepc;
    logic        illegal, irq_req;
    logic [4:0]  irq_cause;
    logic [1:0]  priv;
    int          n_vec = 0, n_bad = 0;

    // model state
    logic [1:0]  m_priv;
    logic [31:0] m_status, m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [2:0]  m_lines;
    logic [63:0] m_cyc, m_ins;
    logic [11:0] all_addrs [18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                                    12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0};
    logic [11:0] wr_addrs [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00,
                                   12'hB02, 12'hB80, 12'hB82, 12'h301, 12'hF11, 12'hF14, 12'h344, 12'h7C0};

    csr_trap_unit dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(wa), .wdata_i(wd), .raddr_i(ra), .rdata_o(rdata),
        .illegal_o(illegal), .trap_i(trap), .trap_cause_i(tcause), .trap_pc_i(tpc), .trap_val_i(tval),
        .mret_i(mret), .retire_i(retire), .irq_ext_i(ext), .irq_tmr_i(tmr), .irq_sw_i(sw),
        .irq_req_o(irq_req), .irq_cause_o(irq_cause), .irq_take_i(take), .trap_target_o(target),
        .mepc_o(mepc), .priv_o(priv)
    );

    always #5 clk = ~clk;

    function automatic bit m_known(input logic [11:0] a);
        for (int k = 0; k < 17; k++) if (all_addrs[k] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ro(input logic [11:0] a);
        return a == 12'h301 || (a >= 12'hF11 && a <= 12'hF14);
    endfunction

    function automatic logic [31:0] m_mip();
        return (32'(m_lines[2]) << 11) | (32'(m_lines[1]) << 7) | (32'(m_lines[0]) << 3);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_status;
            12'h301: return 32'h4010_0100;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_mip();
            12'hB00: return m_cyc[31:0];
            12'hB02: return m_ins[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [4:0] m_win();
        logic [31:0] p = m_mip() & m_ie;
        int prio [3] = '{11, 3, 7};
        foreach (prio[k]) if (p[prio[k]]) return 5'(prio[k]);
        return 5'd0;
    endfunction

    function automatic bit m_req();
        return (m_priv == 2'b00 || m_status[3]) && (m_mip() & m_ie) != 0;
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] b = m_tvec & ~32'h3;
        return (m_tvec[1:0] == 2'b01 && m_req() && !trap) ? b + 4 * m_win() : b;
    endfunction

    function automatic bit m_illegal();
        return !m_known(ra) || m_priv == 2'b00 || (we && (!m_known(wa) || m_ro(wa)));
    endfunction

    task automatic model_update();
        bit wr;
        logic [63:0] c, r;
        logic [4:0] ic;
        if (rst) begin
            m_priv = 2'b11; m_status = 32'h1800; m_ie = 0; m_tvec = 0; m_scratch = 0;
            m_epc = 0; m_cause = 0; m_tval = 0; m_lines = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        wr = we && m_priv == 2'b11 && m_known(wa) && !m_ro(wa) && !trap && !take && !mret;
        c = m_cyc + 1;
        r = m_ins + 64'(retire);
        if (wr && wa == 12'hB00) c[31:0] = wd;
        if (wr && wa == 12'hB80) c[63:32] = wd;
        if (wr && wa == 12'hB02) r[31:0] = wd;
        if (wr && wa == 12'hB82) r[63:32] = wd;
        ic = m_win();
        if (trap || take) begin
            m_epc = tpc & ~32'h3;
            m_cause = trap ? 32'(tcause) : (32'h8000_0000 | 32'(ic));
            m_tval = trap ? tval : 32'h0;
            m_status = (m_status[3] ? 32'h80 : 32'h0) | {19'b0, m_priv, 11'b0};
            m_priv = 2'b11;
        end else if (mret) begin
            m_priv = m_status[12:11];
            m_status = (m_status[7] ? 32'h8 : 32'h0) | 32'h80;
        end else if (wr) begin
            case (wa)
                12'h300: m_status = (wd & 32'h88) | (wd[12:11] == 2'b11 ? 32'h1800 : 32'h0);
                12'h304: m_ie = wd & 32'h888;
                12'h305: m_tvec = (wd & ~32'h3) | (wd[1] ? (m_tvec & 32'h3) : (wd & 32'h3));
                12'h340: m_scratch = wd;
                12'h341: m_epc = wd & ~32'h3;
                12'h342: m_cause = wd;
                12'h343: m_tval = wd;
                default: ;
            endcase
        end
        m_lines = {ext, tmr, sw};
        m_cyc = c;
        m_ins = r;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; wa = 12'h340; wd = $urandom; trap = 1'b1; mret = 1'b1;
        tick(); tick();
        rst = 1'b0; we = 1'b0; trap = 1'b0; mret = 1'b0; ra = 12'h300;
        #1;
        n_vec++; if (priv !== 2'b11) begin n_bad++; $display("FAIL reset_priv: got %b want 11", priv); end
        n_vec++; if (rdata !== 32'h1800) begin n_bad++; $display("FAIL reset_mstatus: got %h want 00001800", rdata); end
        n_vec++; if (irq_req !== 1'b0 || illegal !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got req=%b ill=%b want 0 0", irq_req, illegal); end
        n_vec++; if (mepc !== 32'h0 || target !== 32'h0) begin n_bad++; $display("FAIL reset_mepc_target: got %h %h want 0 0", mepc, target); end
        foreach (all_addrs[k]) begin
            ra = all_addrs[k];
            #1;
            n_vec++;
            if (rdata !== m_read(ra) || illegal !== m_illegal()) begin
                n_bad++;
                $display("FAIL reset_read %h: got %h/%b want %h/%b", ra, rdata, illegal, m_read(ra), m_illegal());
            end
            tick();
        end
    endtask

    task automatic test_rw();
        for (int i = 0; i < 40; i++) begin
            we = 1'b1; wa = wr_addrs[$urandom_range(0, 15)]; wd = $urandom; ra = wa;
            #1;
            n_vec++; if (illegal !== m_illegal()) begin n_bad++; $display("FAIL rw_illegal %h: got %b want %b", wa, illegal, m_illegal()); end
            tick();
            we = 1'b0;
            n_vec++;
            if (rdata !== m_read(ra)) begin n_bad++; $display("FAIL rw_read %h: got %h want %h", ra, rdata, m_read(ra)); end
        end
    endtask

    task automatic test_irq();
        csr_write(12'h305, 32'h101); csr_write(12'h304, 32'h800); csr_write(12'h300, 32'h8);
        ext = 1'b1;
        tick();
        n_vec++;
        if (irq_req !== 1'b1 || irq_cause !== 5'd11 || target !== 32'h12C) begin
            n_bad++; $display("FAIL irq_vectored: got %b/%0d/%h want 1/11/0000012c", irq_req, irq_cause, target);
        end
        ext = 1'b0;
        tick();
        n_vec++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL irq_drop: got %b want 0", irq_req); end
        csr_write(12'h304, 32'h888);
        {ext, tmr, sw} = 3'b111;
        tick();
        n_vec++; if (irq_cause !== 5'd11) begin n_bad++; $display("FAIL prio_all: got %0d want 11", irq_cause); end
        ext = 1'b0;
        tick();
        n_vec++; if (irq_cause !== 5'd3) begin n_bad++; $display("FAIL prio_no_ext: got %0d want 3", irq_cause); end
        sw = 1'b0;
        tick();
        n_vec++; if (irq_cause !== 5'd7) begin n_bad++; $display("FAIL prio_tmr: got %0d want 7", irq_cause); end
        for (int i = 0; i < 24; i++) begin
            {ext, tmr, sw} = 3'($urandom);
            if (i % 5 == 0) begin we = 1'b1; wa = 12'h300; wd = $urandom; end
            tick();
            we = 1'b0;
            n_vec++;
            if (irq_req !== m_req() || irq_cause !== m_win() || target !== m_target()) begin
                n_bad++;
                $display("FAIL irq_rand: got %b/%0d/%h want %b/%0d/%h", irq_req, irq_cause, target, m_req(), m_win(), m_target());
            end
        end
        {ext, tmr, sw} = 3'b000;
        tick();
    endtask

    task automatic test_trap_mret();
        csr_write(12'h300, 32'h80);
        mret = 1'b1;
        tick();
        mret = 1'b0; ra = 12'h300;
        #1;
        n_vec++; if (priv !== 2'b00 || illegal !== 1'b1) begin n_bad++; $display("FAIL umode_access: got %b/%b want 00/1", priv, illegal); end
        trap = 1'b1; tcause = 5'd2; tpc = 32'h80; tval = 32'h1234;
        tick();
        trap = 1'b0;
        n_vec++; if (priv !== 2'b11 || mepc !== 32'h80) begin n_bad++; $display("FAIL trap_entry: got %b/%h want 11/00000080", priv, mepc); end
        ra = 12'h342; #1;
        n_vec++; if (rdata !== 32'h2) begin n_bad++; $display("FAIL trap_mcause: got %h want 00000002", rdata); end
        ra = 12'h300; #1;
        n_vec++; if (rdata[12:11] !== 2'b00 || rdata !== m_read(ra)) begin n_bad++; $display("FAIL trap_mstatus: got %h want %h", rdata, m_read(ra)); end
        ra = 12'h343; #1;
        n_vec++; if (rdata !== 32'h1234) begin n_bad++; $display("FAIL trap_mtval: got %h want 00001234", rdata); end
        mret = 1'b1;
        tick();
        mret = 1'b0; ra = 12'h300;
        #1;
        n_vec++; if (priv !== 2'b00 || rdata[3] !== 1'b1 || rdata !== m_read(ra)) begin n_bad++; $display("FAIL mret: got %b/%h want 00/%h", priv, rdata, m_read(ra)); end
        sw = 1'b1;
        tick();
        n_vec++; if (irq_req !== 1'b1 || irq_cause !== 5'd3 || target !== 32'h10C) begin n_bad++; $display("FAIL umode_irq: got %b/%0d/%h want 1/3/0000010c", irq_req, irq_cause, target); end
        take = 1'b1; tpc = 32'h203;
        tick();
        take = 1'b0; sw = 1'b0; ra = 12'h342;
        #1;
        n_vec++; if (priv !== 2'b11 || mepc !== 32'h200 || rdata !== 32'h8000_0003) begin n_bad++; $display("FAIL irq_take: got %b/%h/%h want 11/00000200/80000003", priv, mepc, rdata); end
        ra = 12'h343; #1;
        n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL irq_mtval: got %h want 0", rdata); end
        csr_write(12'h340, 32'hAAAA_5555);
        we = 1'b1; wa = 12'h340; wd = 32'h1234; trap = 1'b1; take = 1'b1; mret = 1'b1; tcause = 5'd5; tpc = 32'h44;
        tick();
        {we, trap, take, mret} = 4'b0;
        ra = 12'h340; #1;
        n_vec++; if (rdata !== 32'hAAAA_5555) begin n_bad++; $display("FAIL collide_mscratch: got %h want aaaa5555", rdata); end
        ra = 12'h342; #1;
        n_vec++; if (rdata !== 32'h5 || mepc !== 32'h44) begin n_bad++; $display("FAIL collide_trap_wins: got %h/%h want 00000005/00000044", rdata, mepc); end
        we = 1'b1; wa = 12'h340; wd = 32'h9999; mret = 1'b1;
        tick();
        we = 1'b0; mret = 1'b0; ra = 12'h340; #1;
        n_vec++; if (rdata !== m_read(ra) || priv !== m_priv) begin n_bad++; $display("FAIL mret_beats_write: got %h/%b want %h/%b", rdata, priv, m_read(ra), m_priv); end
    endtask

    task automatic test_counters();
        csr_write(12'hB80, 32'h5); csr_write(12'hB00, 32'hFFFF_FFFF);
        ra = 12'hB00; #1;
        n_vec++; if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cyc_set_lo: got %h want ffffffff", rdata); end
        ra = 12'hB80; #1;
        n_vec++; if (rdata !== 32'h5) begin n_bad++; $display("FAIL cyc_set_hi: got %h want 00000005", rdata); end
        tick();
        ra = 12'hB00; #1;
        n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL cyc_wrap_lo: got %h want 0", rdata); end
        ra = 12'hB80; #1;
        n_vec++; if (rdata !== 32'h6) begin n_bad++; $display("FAIL cyc_wrap_hi: got %h want 6", rdata); end
        csr_write(12'hB80, 32'h5); csr_write(12'hB00, 32'hFFFF_FFFF); csr_write(12'hB00, 32'h10);
        ra = 12'hB00; #1;
        n_vec++; if (rdata !== 32'h10) begin n_bad++; $display("FAIL cyc_ovr_lo: got %h want 00000010", rdata); end
        ra = 12'hB80; #1;
        n_vec++; if (rdata !== 32'h6) begin n_bad++; $display("FAIL cyc_ovr_hi: got %h want 6", rdata); end
        csr_write(12'hB82, 32'hFFFF_FFFF); csr_write(12'hB02, 32'hFFFF_FFFF);
        retire = 1'b1;
        tick();
        retire = 1'b0; ra = 12'hB02; #1;
        n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL ins_wrap_lo: got %h want 0", rdata); end
        ra = 12'hB82; #1;
        n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL ins_wrap_hi: got %h want 0", rdata); end
        for (int i = 0; i < 20; i++) begin
            retire = 1'($urandom);
            tick();
            retire = 1'b0; ra = (i % 2 == 0) ? 12'hB02 : 12'hB00; #1;
            n_vec++; if (rdata !== m_read(ra)) begin n_bad++; $display("FAIL counter_rand %h: got %h want %h", ra, rdata, m_read(ra)); end
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_irq();
        test_trap_mret();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
